// File: rtl/sram_arbiter.sv
// Purpose: shares one external asynchronous SRAM port between CPU (rd/wr), VGA (rd) and audio (rd),
//          running each grant as a fixed access: IDLE -> ACCESS (WAIT_CYCLES) -> DONE (ack) -> IDLE.
// Ports:   per-requester req/addr(/we/din) in, one-cycle ack and held read data out;
//          SRAM address/data/strobes (CE/OE/WE active-low) out; busy and owner status out.
// Latency: ack arrives 1+WAIT_CYCLES cycles after req is sampled in IDLE; requests are taken only
//          in IDLE, and a requester holds req until its ack (no other backpressure).
module sram_arbiter #(
   parameter int DW          = 16,
   parameter int AW          = 16,
   parameter int WAIT_CYCLES = 1,
   parameter int VGA_MAX     = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_dout,
   input  logic          vga_req,
   input  logic [AW-1:0] vga_addr,
   output logic          vga_ack,
   output logic [DW-1:0] vga_dout,
   input  logic          aud_req,
   input  logic [AW-1:0] aud_addr,
   output logic          aud_ack,
   output logic [DW-1:0] aud_dout,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_din,
   input  logic [DW-1:0] sram_dout,
   output logic          SRAM_CE,
   output logic          SRAM_OE,
   output logic          SRAM_WE,
   output logic          busy,
   output logic [1:0]    owner
);

   localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int SCW = $clog2(VGA_MAX + 1);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_VGA  = 2'd2;
   localparam logic [1:0] OWN_AUD  = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t          state, state_d;
   logic [WCW-1:0]  wait_cnt, wait_cnt_d;
   logic [SCW-1:0]  streak, streak_d;
   logic            rr_aud, rr_aud_d;     // 1: audio wins the next CPU/audio tie
   logic            wr, wr_d;             // current access is a write
   logic [AW-1:0]   sram_addr_d;
   logic [DW-1:0]   sram_din_d;
   logic            ce_d, oe_d, we_d;
   logic            cpu_ack_d, vga_ack_d, aud_ack_d;
   logic [DW-1:0]   cpu_dout_d, vga_dout_d, aud_dout_d;
   logic            busy_d;
   logic [1:0]      owner_d;

   logic            others_pend;
   logic            guard_hit;
   logic            pick_aud;

   always_comb begin
      state_d     = state;
      wait_cnt_d  = wait_cnt;
      streak_d    = streak;
      rr_aud_d    = rr_aud;
      wr_d        = wr;
      sram_addr_d = sram_addr;
      sram_din_d  = sram_din;
      ce_d        = SRAM_CE;
      oe_d        = SRAM_OE;
      we_d        = SRAM_WE;
      cpu_ack_d   = 1'b0;
      vga_ack_d   = 1'b0;
      aud_ack_d   = 1'b0;
      cpu_dout_d  = cpu_dout;
      vga_dout_d  = vga_dout;
      aud_dout_d  = aud_dout;
      busy_d      = busy;
      owner_d     = owner;

      others_pend = cpu_req | aud_req;
      // VGA loses this grant once it has won VGA_MAX in a row over a waiting requester
      guard_hit   = others_pend && (streak == SCW'(VGA_MAX));
      // CPU/audio round-robin winner; only meaningful when one of them is requesting
      pick_aud    = aud_req && (!cpu_req || rr_aud);

      unique case (state)
         S_IDLE: begin
            if (vga_req || others_pend) begin
               if (vga_req && !guard_hit) begin
                  owner_d     = OWN_VGA;
                  sram_addr_d = vga_addr;
                  wr_d        = 1'b0;
                  streak_d    = others_pend ? streak + 1'b1 : '0;
               end else if (pick_aud) begin
                  owner_d     = OWN_AUD;
                  sram_addr_d = aud_addr;
                  wr_d        = 1'b0;
                  streak_d    = '0;
                  rr_aud_d    = 1'b0;
               end else begin
                  owner_d     = OWN_CPU;
                  sram_addr_d = cpu_addr;
                  sram_din_d  = cpu_din;
                  wr_d        = cpu_we;
                  streak_d    = '0;
                  rr_aud_d    = 1'b1;
               end
               ce_d       = 1'b0;
               // only a CPU grant can carry a write
               oe_d       = (owner_d == OWN_CPU) && cpu_we;
               we_d       = !((owner_d == OWN_CPU) && cpu_we);
               busy_d     = 1'b1;
               wait_cnt_d = '0;
               state_d    = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (wait_cnt == WCW'(WAIT_CYCLES - 1)) begin
               ce_d    = 1'b1;
               oe_d    = 1'b1;
               we_d    = 1'b1;
               state_d = S_DONE;
               unique case (owner)
                  OWN_CPU: begin
                     cpu_ack_d = 1'b1;
                     if (!wr) cpu_dout_d = sram_dout;
                  end
                  OWN_VGA: begin
                     vga_ack_d  = 1'b1;
                     vga_dout_d = sram_dout;
                  end
                  OWN_AUD: begin
                     aud_ack_d  = 1'b1;
                     aud_dout_d = sram_dout;
                  end
                  default: ;
               endcase
            end else begin
               wait_cnt_d = wait_cnt + 1'b1;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            owner_d = OWN_NONE;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         streak    <= '0;
         rr_aud    <= 1'b0;
         wr        <= 1'b0;
         sram_addr <= '0;
         sram_din  <= '0;
         SRAM_CE   <= 1'b1;
         SRAM_OE   <= 1'b1;
         SRAM_WE   <= 1'b1;
         cpu_ack   <= 1'b0;
         vga_ack   <= 1'b0;
         aud_ack   <= 1'b0;
         cpu_dout  <= '0;
         vga_dout  <= '0;
         aud_dout  <= '0;
         busy      <= 1'b0;
         owner     <= OWN_NONE;
      end else begin
         state     <= state_d;
         wait_cnt  <= wait_cnt_d;
         streak    <= streak_d;
         rr_aud    <= rr_aud_d;
         wr        <= wr_d;
         sram_addr <= sram_addr_d;
         sram_din  <= sram_din_d;
         SRAM_CE   <= ce_d;
         SRAM_OE   <= oe_d;
         SRAM_WE   <= we_d;
         cpu_ack   <= cpu_ack_d;
         vga_ack   <= vga_ack_d;
         aud_ack   <= aud_ack_d;
         cpu_dout  <= cpu_dout_d;
         vga_dout  <= vga_dout_d;
         aud_dout  <= aud_dout_d;
         busy      <= busy_d;
         owner     <= owner_d;
      end
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Sequences and shares the single external SRAM port between three requesters: CPU (read/write), VGA controller (read-only) and audio controller (read-only). It runs each granted request as a fixed-length SRAM access and drives the active-low CE/OE/WE strobes, address and write data. It returns read data and a one-cycle acknowledge to the owner. It sits between the requesters and the SRAM, in place of direct CPU-to-SRAM wiring.

Parameters:
DW, 16, data width
AW, 16, SRAM address width
WAIT_CYCLES, 1, cycles the strobes are held active per access (>=1)
VGA_MAX, 4, max consecutive VGA grants while another requester is pending

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
cpu_req  in  1  CPU access request
cpu_we  in  1  1=write, 0=read
cpu_addr  in  AW  CPU address
cpu_din  in  DW  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_dout  out  DW  CPU read data
vga_req  in  1  VGA read request
vga_addr  in  AW  VGA address
vga_ack  out  1  completion pulse
vga_dout  out  DW  VGA read data
aud_req  in  1  audio read request
aud_addr  in  AW  audio address
aud_ack  out  1  completion pulse
aud_dout  out  DW  audio read data
sram_addr  out  AW  SRAM address
sram_din  out  DW  SRAM write data
sram_dout  in  DW  SRAM read data, valid the cycle after OE low with address stable
SRAM_CE  out  1  chip enable, active-low
SRAM_OE  out  1  output enable, active-low
SRAM_WE  out  1  write enable, active-low
busy  out  1  high in ACCESS and DONE
owner  out  2  0=none, 1=CPU, 2=VGA, 3=audio

Behaviour:
- Reset values: SRAM_CE/OE/WE=1, sram_addr=0, sram_din=0, all acks=0, all dout=0, busy=0, owner=0, state IDLE, rr pointer=CPU, VGA streak counter=0.
- All outputs are registered.
- States:
  - IDLE: if any req is high, arbitrate, latch the winner's addr/we/din into sram_addr/sram_din, set owner, go to ACCESS.
  - ACCESS: CE=0. Read: OE=0, WE=1. Write: WE=0, OE=1. Stay WAIT_CYCLES cycles (wait counter), then go to DONE.
  - DONE: CE/OE/WE=1. Owner's ack=1 for exactly this cycle. Go to IDLE.
- Read data: sram_dout is sampled at the edge leaving the last ACCESS cycle into the owner's dout. dout is valid in the ack cycle and held until that owner's next read ack.
- Writes leave cpu_dout unchanged. A VGA or audio request never writes; SRAM_WE stays 1.
- Latency with WAIT_CYCLES=1: req sampled in IDLE at cycle T, ACCESS at T+1, ack at T+2. Access period is 2+WAIT_CYCLES cycles.
- Requester rule: hold req until ack. req must be low in the cycle after ack unless a new access is intended; a high req there starts a new access.
- The arbiter samples req only in IDLE. Dropping req mid-access does not abort; the access completes and acks.
- Arbitration:
  - VGA has highest priority.
  - CPU and audio share round-robin. The pointer flips to the other one after each CPU or audio grant, and is unchanged by VGA grants.
  - Starvation guard: the streak counter increments on each VGA grant made while cpu_req or aud_req is high; otherwise it resets to 0. When the counter equals VGA_MAX and CPU/audio is pending, that grant goes to the round-robin winner instead of VGA, and the counter resets to 0.
  - Simultaneous CPU and audio requests with no VGA request: the rr pointer decides.
- Reset mid-operation: at the next edge, force IDLE, deassert strobes, issue no ack, and do not retry the aborted access.
- busy=1 in ACCESS and DONE. owner returns to 0 in IDLE.

Test Plan:
- CPU write 0xBEEF to 0x0010, then CPU read 0x0010 (SRAM model) -> in ACCESS of the write, WE=0/CE=0 for 1 cycle with sram_din=0xBEEF; cpu_ack 2 cycles after req is sampled; read returns cpu_dout=0xBEEF with cpu_ack.
- vga_req, cpu_req and aud_req all held high continuously, VGA_MAX=4 -> grant order VGA×4, CPU, VGA×4, audio, VGA×4, CPU.
- cpu_req and aud_req high together from reset, no VGA -> grants alternate CPU, audio, CPU, audio; each ack is exactly one cycle.
- VGA read 0x1234 (mem=0x00AA) followed by audio read 0x1235 (mem=0x0055) -> vga_dout=0x00AA, aud_dout=0x0055; cpu_dout stays 0; SRAM_WE never 0.
- rst asserted during ACCESS of a CPU write -> next cycle CE/OE/WE=1, busy=0, owner=0, no cpu_ack, memory at that address unchanged if WE was never low.
- WAIT_CYCLES=3 read -> CE/OE low for 3 cycles; ack 4 cycles after req is sampled; data captured from the last ACCESS cycle.
